// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared widths, encodings and FSM state type for the fetch stage
//
// Purpose : single source for the fetch-stage word widths, the NOP and halt
//           encodings, and the two-state fetch FSM encoding.
// Contents: PC_W, INSTR_W, NOP_INSTR, HALT_WORD, state_t {FETCH, HALTED}.

package fetch_stage_pkg;

    localparam int PC_W    = 8;
    localparam int INSTR_W = 32;

    // All-zero word is the architectural NOP handed to decode for bubbles.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // Fetching this word stops the stage for good (until reset).
    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

    typedef enum logic {
        FETCH  = 1'b0,
        HALTED = 1'b1
    } state_t;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// rtl/fetch_stage_if_id_reg.sv - IF/ID pipeline register with load, hold and bubble controls
//
// Purpose : holds the instruction, its PC+1 and a valid flag between fetch
//           and decode.
// Ports   : clk, rst_n      - clock, asynchronous active-low reset
//           bubble          - clear to NOP / pc1=0 / valid=0 (wins over load)
//           load            - capture instr / pc1 and mark valid
//                             (neither asserted: hold current contents)
//           instr, pc1      - values captured on load
//           instr_q, pc1_q, valid_q - registered contents seen by decode

module if_id_reg #(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               bubble,
    input  logic               load,
    input  logic [INSTR_W-1:0] instr,
    input  logic [PC_W-1:0]    pc1,
    output logic [INSTR_W-1:0] instr_q,
    output logic [PC_W-1:0]    pc1_q,
    output logic               valid_q
);

    import fetch_stage_pkg::*;

    localparam logic [INSTR_W-1:0] NOP = INSTR_W'(NOP_INSTR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q <= NOP;
            pc1_q   <= '0;
            valid_q <= 1'b0;
        end else if (bubble) begin
            instr_q <= NOP;
            pc1_q   <= '0;
            valid_q <= 1'b0;
        end else if (load) begin
            instr_q <= instr;
            pc1_q   <= pc1;
            valid_q <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch: PC, next-PC selection, halt FSM and IF/ID register
//
// Purpose : owns the program counter, presents it as the word address to the
//           instruction memory, takes the instruction back in the same cycle
//           and registers it with PC+1 into IF/ID for decode.
// Ports   : clk, rst_n                      - clock, async active-low reset
//           pc_o                            - current PC / imem word address
//           instr_i                         - imem data for pc_o (combinational)
//           stall_i                         - hold PC and IF/ID
//           flush_i                         - bubble IF/ID
//           branch_taken_i, branch_target_i - redirect (highest priority)
//           jump_i, jump_target_i           - redirect (below branch)
//           if_id_instr_o, if_id_pc1_o, if_id_valid_o - IF/ID contents
//           halted_o                        - fetch stopped on the halt word

module fetch_stage #(
    parameter int                  PC_W      = fetch_stage_pkg::PC_W,
    parameter int                  INSTR_W   = fetch_stage_pkg::INSTR_W,
    parameter logic [PC_W-1:0]     RESET_PC  = '0,
    parameter logic [INSTR_W-1:0]  HALT_WORD = INSTR_W'(fetch_stage_pkg::HALT_WORD)
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [PC_W-1:0]    pc_o,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic               stall_i,
    input  logic               flush_i,
    input  logic               branch_taken_i,
    input  logic [PC_W-1:0]    branch_target_i,
    input  logic               jump_i,
    input  logic [PC_W-1:0]    jump_target_i,
    output logic [INSTR_W-1:0] if_id_instr_o,
    output logic [PC_W-1:0]    if_id_pc1_o,
    output logic               if_id_valid_o,
    output logic               halted_o
);

    import fetch_stage_pkg::*;

    state_t          state;
    state_t          state_next;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_next;
    logic [PC_W-1:0] pc_plus1;
    logic            redirect;
    logic            is_halt_word;
    logic            halt_detect;
    logic            ifid_load;
    logic            ifid_bubble;

    // Natural wrap at 2^PC_W; no overflow indication is wanted.
    assign pc_plus1     = pc + 1'b1;
    assign redirect     = branch_taken_i | jump_i;
    assign is_halt_word = (instr_i == HALT_WORD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH;
            pc    <= RESET_PC;
        end else begin
            state <= state_next;
            pc    <= pc_next;
        end
    end

    always_comb begin
        state_next  = state;
        pc_next     = pc;
        halt_detect = 1'b0;
        ifid_load   = 1'b0;
        ifid_bubble = 1'b0;

        case (state)
            FETCH: begin
                // A halt word under redirect is wrong-path and is discarded;
                // under stall it is simply looked at again next cycle.
                halt_detect = is_halt_word && !redirect && !stall_i;

                // Redirect beats stall: decode has already resolved the
                // control transfer, so the held fetch is wrong-path anyway.
                // On halt the PC freezes at the halt word's address.
                if (branch_taken_i)
                    pc_next = branch_target_i;
                else if (jump_i)
                    pc_next = jump_target_i;
                else if (stall_i || halt_detect)
                    pc_next = pc;
                else
                    pc_next = pc_plus1;

                // The halt word itself is never passed on to decode.
                if (flush_i || redirect || halt_detect)
                    ifid_bubble = 1'b1;
                else if (!stall_i)
                    ifid_load = 1'b1;

                if (halt_detect)
                    state_next = HALTED;
            end

            HALTED: begin
                // Sticky: every control input is ignored, decode sees bubbles.
                ifid_bubble = 1'b1;
            end

            default: begin
                state_next  = FETCH;
                ifid_bubble = 1'b1;
            end
        endcase
    end

    if_id_reg #(
        .PC_W    (PC_W),
        .INSTR_W (INSTR_W)
    ) u_if_id_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .bubble  (ifid_bubble),
        .load    (ifid_load),
        .instr   (instr_i),
        .pc1     (pc_plus1),
        .instr_q (if_id_instr_o),
        .pc1_q   (if_id_pc1_o),
        .valid_q (if_id_valid_o)
    );

    assign pc_o     = pc;
    assign halted_o = (state == HALTED);

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage

module tb_fetch_stage;

    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  pc;
    logic [31:0] instr;
    logic        stall, flush, branch, jump;
    logic [7:0]  branch_target, jump_target;
    logic [31:0] if_id_instr;
    logic [7:0]  if_id_pc1;
    logic        if_id_valid;
    logic        halted;

    logic [31:0] mem [256];
    logic [40:0] ifid;
    logic [40:0] exp_ifid;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    assign instr = mem[pc];
    assign ifid  = {if_id_valid, if_id_pc1, if_id_instr};

    fetch_stage dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .pc_o            (pc),
        .instr_i         (instr),
        .stall_i         (stall),
        .flush_i         (flush),
        .branch_taken_i  (branch),
        .branch_target_i (branch_target),
        .jump_i          (jump),
        .jump_target_i   (jump_target),
        .if_id_instr_o   (if_id_instr),
        .if_id_pc1_o     (if_id_pc1),
        .if_id_valid_o   (if_id_valid),
        .halted_o        (halted)
    );

    function automatic logic [31:0] word(input int n);
        return 32'hA500_0000 + 32'(n & 255);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctrl();
        stall = 0; flush = 0; branch = 0; jump = 0;
        branch_target = 8'h00; jump_target = 8'h00;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = word(i);
        clear_ctrl();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 256; i++) mem[i] = word(i);
        mem[0] = HALT;
        clear_ctrl();
        rst_n = 1'b0;
        step();
        vectors++;
        if (pc !== 8'h00) begin $display("FAIL reset_pc: got %h expected 00", pc); errors++; end
        vectors++;
        if (ifid !== 41'h0) begin $display("FAIL reset_ifid: got %h expected 0", ifid); errors++; end
        vectors++;
        if (halted !== 1'b0) begin $display("FAIL reset_halted: got %b expected 0", halted); errors++; end
        rst_n = 1'b1;
    endtask

    task automatic test_halt_at_reset();
        step();
        vectors++;
        if ({halted, pc, ifid} !== {1'b1, 8'h00, 41'h0})
            begin $display("FAIL halt_first: got h=%b pc=%h ifid=%h expected h=1 pc=00 ifid=0", halted, pc, ifid); errors++; end
        for (int i = 0; i < 20; i++) begin
            // Control inputs must be ignored once halted.
            branch = (i >= 10); branch_target = 8'h55;
            flush  = (i >= 10); jump = (i >= 15); jump_target = 8'h77;
            step();
            vectors++;
            if ({halted, pc, ifid} !== {1'b1, 8'h00, 41'h0})
                begin $display("FAIL halt_hold_%0d: got h=%b pc=%h ifid=%h expected h=1 pc=00 ifid=0", i, halted, pc, ifid); errors++; end
        end
        clear_ctrl();
    endtask

    task automatic test_sequential();
        do_reset();
        vectors++;
        if (pc !== 8'h00) begin $display("FAIL seq_pc0: got %h expected 00", pc); errors++; end
        for (int k = 1; k <= 4; k++) begin
            step();
            exp_ifid = {1'b1, 8'(k), word(k - 1)};
            vectors++;
            if (pc !== 8'(k)) begin $display("FAIL seq_pc_%0d: got %h expected %h", k, pc, 8'(k)); errors++; end
            vectors++;
            if (ifid !== exp_ifid) begin $display("FAIL seq_ifid_%0d: got %h expected %h", k, ifid, exp_ifid); errors++; end
        end
    endtask

    task automatic test_stall();
        step();
        exp_ifid = {1'b1, 8'h05, word(4)};
        vectors++;
        if ({pc, ifid} !== {8'h05, exp_ifid}) begin $display("FAIL stall_pre: got pc=%h ifid=%h expected pc=05 ifid=%h", pc, ifid, exp_ifid); errors++; end
        stall = 1;
        for (int i = 0; i < 2; i++) begin
            step();
            vectors++;
            if ({pc, ifid} !== {8'h05, exp_ifid}) begin $display("FAIL stall_hold_%0d: got pc=%h ifid=%h expected pc=05 ifid=%h", i, pc, ifid, exp_ifid); errors++; end
        end
        stall = 0;
        step();
        exp_ifid = {1'b1, 8'h06, word(5)};
        vectors++;
        if ({pc, ifid} !== {8'h06, exp_ifid}) begin $display("FAIL stall_resume: got pc=%h ifid=%h expected pc=06 ifid=%h", pc, ifid, exp_ifid); errors++; end
    endtask

    task automatic test_branch_priority();
        do_reset();
        repeat (3) step();
        vectors++;
        if (pc !== 8'h03) begin $display("FAIL br_pre_pc: got %h expected 03", pc); errors++; end
        branch = 1; branch_target = 8'h40;
        jump   = 1; jump_target   = 8'h80;
        step();
        vectors++;
        if ({pc, ifid} !== {8'h40, 41'h0}) begin $display("FAIL br_redirect: got pc=%h ifid=%h expected pc=40 ifid=0", pc, ifid); errors++; end
        clear_ctrl();
        step();
        exp_ifid = {1'b1, 8'h41, word(8'h40)};
        vectors++;
        if ({pc, ifid} !== {8'h41, exp_ifid}) begin $display("FAIL br_target_fetch: got pc=%h ifid=%h expected pc=41 ifid=%h", pc, ifid, exp_ifid); errors++; end
    endtask

    task automatic test_flush();
        flush = 1;
        step();
        vectors++;
        if ({pc, ifid} !== {8'h42, 41'h0}) begin $display("FAIL flush_adv: got pc=%h ifid=%h expected pc=42 ifid=0", pc, ifid); errors++; end
        stall = 1;
        step();
        vectors++;
        if ({pc, ifid} !== {8'h42, 41'h0}) begin $display("FAIL flush_stall: got pc=%h ifid=%h expected pc=42 ifid=0", pc, ifid); errors++; end
        clear_ctrl();
        step();
        exp_ifid = {1'b1, 8'h43, word(8'h42)};
        vectors++;
        if ({pc, ifid} !== {8'h43, exp_ifid}) begin $display("FAIL flush_resume: got pc=%h ifid=%h expected pc=43 ifid=%h", pc, ifid, exp_ifid); errors++; end
    endtask

    task automatic test_wrap_and_redirect_halt();
        jump = 1; jump_target = 8'hFF;
        step();
        vectors++;
        if (pc !== 8'hFF) begin $display("FAIL wrap_pre: got %h expected ff", pc); errors++; end
        jump = 0;
        mem[1] = HALT;
        step();
        exp_ifid = {1'b1, 8'h00, word(255)};
        vectors++;
        if ({pc, ifid} !== {8'h00, exp_ifid}) begin $display("FAIL wrap: got pc=%h ifid=%h expected pc=00 ifid=%h", pc, ifid, exp_ifid); errors++; end
        step();
        vectors++;
        if (pc !== 8'h01) begin $display("FAIL redir_halt_pre: got %h expected 01", pc); errors++; end
        branch = 1; branch_target = 8'h20;
        step();
        vectors++;
        if ({halted, pc, ifid} !== {1'b0, 8'h20, 41'h0}) begin $display("FAIL redir_halt: got h=%b pc=%h ifid=%h expected h=0 pc=20 ifid=0", halted, pc, ifid); errors++; end
        clear_ctrl();
        mem[1] = word(1);
        mem[8'h21] = HALT;
        step();
        exp_ifid = {1'b1, 8'h21, word(8'h20)};
        vectors++;
        if ({halted, pc, ifid} !== {1'b0, 8'h21, exp_ifid}) begin $display("FAIL redir_halt_post: got h=%b pc=%h ifid=%h expected h=0 pc=21 ifid=%h", halted, pc, ifid, exp_ifid); errors++; end
        // Stalled halt word: no halt yet, IF/ID holds.
        stall = 1;
        step();
        vectors++;
        if ({halted, pc, ifid} !== {1'b0, 8'h21, exp_ifid}) begin $display("FAIL stall_halt: got h=%b pc=%h ifid=%h expected h=0 pc=21 ifid=%h", halted, pc, ifid, exp_ifid); errors++; end
        stall = 0;
        step();
        vectors++;
        if ({halted, pc, ifid} !== {1'b1, 8'h21, 41'h0}) begin $display("FAIL stall_halt_release: got h=%b pc=%h ifid=%h expected h=1 pc=21 ifid=0", halted, pc, ifid); errors++; end
    endtask

    task automatic test_async_reset();
        stall = 1;
        step();
        vectors++;
        if ({halted, pc} !== {1'b1, 8'h21}) begin $display("FAIL areset_pre: got h=%b pc=%h expected h=1 pc=21", halted, pc); errors++; end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({halted, pc, ifid} !== {1'b0, 8'h00, 41'h0}) begin $display("FAIL areset_async: got h=%b pc=%h ifid=%h expected h=0 pc=00 ifid=0", halted, pc, ifid); errors++; end
        mem[8'h21] = word(8'h21);
        clear_ctrl();
        rst_n = 1'b1;
        step();
        exp_ifid = {1'b1, 8'h01, word(0)};
        vectors++;
        if ({halted, pc, ifid} !== {1'b0, 8'h01, exp_ifid}) begin $display("FAIL areset_restart: got h=%b pc=%h ifid=%h expected h=0 pc=01 ifid=%h", halted, pc, ifid, exp_ifid); errors++; end
    endtask

    initial begin
        test_reset();
        test_halt_at_reset();
        test_sequential();
        test_stall();
        test_branch_priority();
        test_flush();
        test_wrap_and_redirect_halt();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage: owns the program counter, drives the word address into the instruction memory and receives the 32-bit instruction back combinationally in the same cycle.
- Selects next PC from sequential / branch / jump sources, honours stall and flush from hazard control, and detects the halt word.
- Registers the fetched instruction and PC+1 into the IF/ID pipeline register consumed by decode.

Parameters:
PC_W, 8, PC / instruction-memory word-address width
INSTR_W, 32, instruction width
RESET_PC, 0, PC value loaded on reset
HALT_WORD, 32'hFFFFFFFF, instruction encoding that stops fetch

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
pc_o  output  PC_W  current PC, word address to instruction memory
instr_i  input  INSTR_W  instruction memory data for pc_o (combinational)
stall_i  input  1  hold PC and IF/ID (load-use hazard)
flush_i  input  1  squash IF/ID contents (bubble)
branch_taken_i  input  1  redirect to branch_target_i
branch_target_i  input  PC_W  branch target word address
jump_i  input  1  redirect to jump_target_i
jump_target_i  input  PC_W  jump target word address
if_id_instr_o  output  INSTR_W  registered instruction to decode
if_id_pc1_o  output  PC_W  registered PC+1 of that instruction
if_id_valid_o  output  1  IF/ID holds a real instruction
halted_o  output  1  fetch stopped on HALT_WORD

Behaviour:
- Reset (rst_n low, asynchronous, any time incl. mid-operation): pc_o=RESET_PC, if_id_instr_o=0 (NOP), if_id_pc1_o=0, if_id_valid_o=0, halted_o=0, state=FETCH.
- States: FETCH, HALTED. FETCH->HALTED when instr_i==HALT_WORD and no redirect and no stall that cycle. HALTED is sticky; only reset leaves it.
- redirect = branch_taken_i | jump_i. Branch and jump resolve in decode; the wrong-path word fetched is the one present in the redirect cycle.
- Next PC priority (FETCH): branch_taken_i -> branch_target_i; else jump_i -> jump_target_i; else stall_i -> hold; else pc_o+1 modulo 2^PC_W (255 wraps to 0, no flag).
- Redirect overrides stall_i for the PC.
- IF/ID priority (FETCH): flush_i or redirect -> instr=0, valid=0, pc1=0; else stall_i -> hold all three; else instr_i==HALT_WORD -> instr=0, valid=0 (halt word never reaches decode); else instr=instr_i, pc1=pc_o+1 (wrapped), valid=1.
- Halt detection is suppressed when redirect or stall_i is high; a stalled halt word is re-evaluated next cycle.
- HALTED: pc_o frozen, all pc/stall/flush/redirect inputs ignored, IF/ID loads NOP with valid=0, halted_o=1. halted_o rises the cycle after the halt word is sampled.
- flush_i without redirect: IF/ID bubbled; PC still advances, or holds if stall_i.
- Latency: instruction at pc_o appears on if_id_* one edge later.

Decomposition:
- Shared package: PC_W, INSTR_W, NOP_INSTR=0, HALT_WORD, state encoding FETCH=1'b0 / HALTED=1'b1.
- One sub-module: if_id_reg. It holds the IF/ID register with load / hold / bubble controls and async active-low reset.
- fetch_stage keeps the PC, next-PC mux and FSM.

Test Plan:
- Memory word0=32'hFFFFFFFF, release reset -> pc_o=0, if_id_valid_o stays 0, halted_o=1 from cycle 2, pc_o stays 0 for 20 cycles.
- Words 0..3 distinct non-halt, no control -> pc_o 0,1,2,3; if_id_instr_o=word[n] with if_id_pc1_o=n+1 one cycle later, valid=1.
- stall_i high 2 cycles at pc=5 -> pc_o stays 5, IF/ID holds word4/pc1=5; resumes at 6 after release.
- branch_taken_i=1, branch_target_i=8'h40 at pc=3, with jump_i=1 to 8'h80 same cycle -> next pc_o=8'h40, IF/ID valid=0 that edge.
- PC=255 sequential -> pc_o wraps to 0, if_id_pc1_o=0 for word255; redirect coinciding with a fetched HALT_WORD -> no halt, pc_o=target.
- Assert rst_n low mid-stall while halted -> outputs return to reset values immediately (asynchronous), fetch restarts at RESET_PC.
